// File: rtl/bp_cce_dir_wg_reader_if.sv
// Command, directory-RAM and result bundle for the directory way-group reader.
// The slave modport is the reader's view; master is the controller/RAM side.
interface bp_cce_dir_wg_reader_if #(
    parameter int unsigned num_lce_p   = 8,
    parameter int unsigned lce_assoc_p = 8,
    parameter int unsigned num_wg_p    = 64,
    parameter int unsigned tag_width_p = 28
);
    localparam int unsigned coh_bits_lp     = 3;
    localparam int unsigned lg_num_lce_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int unsigned lg_lce_assoc_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
    localparam int unsigned lg_num_wg_lp    = (num_wg_p > 1) ? $clog2(num_wg_p) : 1;
    localparam int unsigned entry_width_lp  = tag_width_p + coh_bits_lp;
    localparam int unsigned row_width_lp    = lce_assoc_p * entry_width_lp;

    logic                                    rd_v_i;
    logic                                    ready_o;
    logic [lg_num_wg_lp-1:0]                 wg_i;
    logic [tag_width_p-1:0]                  tag_i;
    logic [lg_num_lce_lp-1:0]                req_lce_i;
    logic [lg_lce_assoc_lp-1:0]              lru_way_i;
    logic                                    clear_i;
    logic                                    ram_v_o;
    logic [lg_num_wg_lp+lg_num_lce_lp-1:0]   ram_addr_o;
    logic [row_width_lp-1:0]                 ram_data_i;
    logic                                    sharers_v_o;
    logic [num_lce_p-1:0]                    sharers_hits_o;
    logic [num_lce_p*lg_lce_assoc_lp-1:0]    sharers_ways_o;
    logic [num_lce_p*coh_bits_lp-1:0]        sharers_coh_states_o;
    logic [coh_bits_lp-1:0]                  lru_coh_state_o;
    logic [tag_width_p-1:0]                  lru_tag_o;
    logic                                    lru_cached_excl_flag_o;
    logic                                    lru_dirty_flag_o;
    logic                                    busy_o;

    modport slave (
        input  rd_v_i, wg_i, tag_i, req_lce_i, lru_way_i, clear_i, ram_data_i,
        output ready_o, ram_v_o, ram_addr_o, sharers_v_o, sharers_hits_o, sharers_ways_o,
               sharers_coh_states_o, lru_coh_state_o, lru_tag_o, lru_cached_excl_flag_o,
               lru_dirty_flag_o, busy_o
    );

    modport master (
        output rd_v_i, wg_i, tag_i, req_lce_i, lru_way_i, clear_i, ram_data_i,
        input  ready_o, ram_v_o, ram_addr_o, sharers_v_o, sharers_hits_o, sharers_ways_o,
               sharers_coh_states_o, lru_coh_state_o, lru_tag_o, lru_cached_excl_flag_o,
               lru_dirty_flag_o, busy_o
    );
endinterface

// File: rtl/bp_cce_dir_wg_reader.sv
// Sequential directory way-group reader: streams one row per LCE out of the directory RAM,
// tag-compares every way and consolidates sharer hits/ways/states plus the LRU entry.
module bp_cce_dir_wg_reader #(
    parameter int unsigned num_lce_p   = 8,
    parameter int unsigned lce_assoc_p = 8,
    parameter int unsigned num_wg_p    = 64,
    parameter int unsigned tag_width_p = 28
) (
    input logic                   clk_i,
    input logic                   reset_i,
    bp_cce_dir_wg_reader_if.slave bus
);
    localparam int unsigned coh_bits_lp     = 3;
    localparam int unsigned lg_num_lce_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int unsigned lg_lce_assoc_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
    localparam int unsigned lg_num_wg_lp    = (num_wg_p > 1) ? $clog2(num_wg_p) : 1;
    localparam int unsigned entry_width_lp  = tag_width_p + coh_bits_lp;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                               state_q, state_d;
    logic [lg_num_wg_lp-1:0]              wg_q;
    logic [tag_width_p-1:0]               tag_q;
    logic [lg_num_lce_lp-1:0]             req_lce_q;
    logic [lg_lce_assoc_lp-1:0]           lru_way_q;
    logic [lg_num_lce_lp-1:0]             cnt_q;
    logic                                 proc_v_q;
    logic [lg_num_lce_lp-1:0]             proc_lce_q;
    logic [num_lce_p-1:0]                 hits_q;
    logic [num_lce_p*lg_lce_assoc_lp-1:0] ways_q;
    logic [num_lce_p*coh_bits_lp-1:0]     states_q;
    logic [coh_bits_lp-1:0]               lru_state_q;
    logic [tag_width_p-1:0]               lru_tag_q;

    logic                                 ready;
    logic                                 accept;
    logic                                 row_hit;
    logic [lg_lce_assoc_lp-1:0]           row_way;
    logic [coh_bits_lp-1:0]               row_state;
    logic [entry_width_lp-1:0]            entry;
    logic [entry_width_lp-1:0]            lru_entry;

    assign ready  = (state_q == StIdle) || (state_q == StDone);
    assign accept = bus.rd_v_i && ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.rd_v_i) state_d = StRead;
            StRead:  if (cnt_q == lg_num_lce_lp'(num_lce_p - 1)) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone: begin
                // A new command takes priority over clear.
                if (bus.rd_v_i)       state_d = StRead;
                else if (bus.clear_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Lowest-index hitting way wins if a row (illegally) holds several matches.
    always_comb begin
        row_hit   = 1'b0;
        row_way   = '0;
        row_state = '0;
        entry     = '0;
        for (int w = 0; w < int'(lce_assoc_p); w++) begin
            entry = bus.ram_data_i[w*entry_width_lp +: entry_width_lp];
            if (!row_hit && (entry[entry_width_lp-1 -: tag_width_p] == tag_q)
                && (entry[coh_bits_lp-1:0] != '0)) begin
                row_hit   = 1'b1;
                row_way   = lg_lce_assoc_lp'(w);
                row_state = entry[coh_bits_lp-1:0];
            end
        end
        lru_entry = bus.ram_data_i[lru_way_q*entry_width_lp +: entry_width_lp];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            wg_q        <= '0;
            tag_q       <= '0;
            req_lce_q   <= '0;
            lru_way_q   <= '0;
            cnt_q       <= '0;
            proc_v_q    <= 1'b0;
            proc_lce_q  <= '0;
            hits_q      <= '0;
            ways_q      <= '0;
            states_q    <= '0;
            lru_state_q <= '0;
            lru_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            // RAM data lands one cycle after the read; track which LCE it belongs to.
            proc_v_q   <= (state_q == StRead);
            proc_lce_q <= cnt_q;
            if (proc_v_q) begin
                hits_q[proc_lce_q]                                     <= row_hit;
                ways_q[proc_lce_q*lg_lce_assoc_lp +: lg_lce_assoc_lp]  <= row_way;
                states_q[proc_lce_q*coh_bits_lp +: coh_bits_lp]        <= row_state;
                if (proc_lce_q == req_lce_q) begin
                    lru_tag_q   <= lru_entry[entry_width_lp-1 -: tag_width_p];
                    lru_state_q <= lru_entry[coh_bits_lp-1:0];
                end
            end
            if (accept) begin
                wg_q        <= bus.wg_i;
                tag_q       <= bus.tag_i;
                req_lce_q   <= bus.req_lce_i;
                lru_way_q   <= bus.lru_way_i;
                cnt_q       <= '0;
                hits_q      <= '0;
                ways_q      <= '0;
                states_q    <= '0;
                lru_state_q <= '0;
                lru_tag_q   <= '0;
            end else if (state_q == StRead) begin
                cnt_q <= cnt_q + lg_num_lce_lp'(1);
            end
        end
    end

    assign bus.ready_o                = ready;
    assign bus.busy_o                 = (state_q == StRead) || (state_q == StDrain);
    assign bus.ram_v_o                = (state_q == StRead);
    assign bus.ram_addr_o             = {wg_q, cnt_q};
    assign bus.sharers_v_o            = (state_q == StDone);
    assign bus.sharers_hits_o         = hits_q;
    assign bus.sharers_ways_o         = ways_q;
    assign bus.sharers_coh_states_o   = states_q;
    assign bus.lru_coh_state_o        = lru_state_q;
    assign bus.lru_tag_o              = lru_tag_q;
    // Bit 0 is the shared bit, bit 2 the dirty bit.
    assign bus.lru_cached_excl_flag_o = (lru_state_q != '0) && !lru_state_q[0];
    assign bus.lru_dirty_flag_o       = (lru_state_q != '0) && lru_state_q[2];
endmodule

// File: tb/tb_bp_cce_dir_wg_reader.sv
// Directed bench for the way-group reader with a 4-LCE directory and a one-cycle RAM model.
module tb_bp_cce_dir_wg_reader;
    localparam int NL = 4;
    localparam int NA = 8;
    localparam int NW = 64;
    localparam int TW = 28;
    localparam int CB = 3;
    localparam int EW = TW + CB;
    localparam int RW = NA * EW;

    localparam logic [2:0] COH_I = 3'b000;
    localparam logic [2:0] COH_S = 3'b001;
    localparam logic [2:0] COH_E = 3'b010;
    localparam logic [2:0] COH_M = 3'b110;
    localparam logic [2:0] COH_O = 3'b111;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    logic [RW-1:0] rows [NL];
    logic [7:0]    addr_q [$];

    bp_cce_dir_wg_reader_if #(
        .num_lce_p(NL), .lce_assoc_p(NA), .num_wg_p(NW), .tag_width_p(TW)
    ) bus ();

    bp_cce_dir_wg_reader #(
        .num_lce_p(NL), .lce_assoc_p(NA), .num_wg_p(NW), .tag_width_p(TW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_v_o) bus.ram_data_i <= rows[bus.ram_addr_o[1:0]];
        else             bus.ram_data_i <= '0;
    end

    task automatic clear_rows();
        for (int i = 0; i < NL; i++) rows[i] = '0;
    endtask

    task automatic set_entry(input int lce, input int way, input logic [TW-1:0] tag,
                             input logic [2:0] st);
        rows[lce][way*EW +: EW] = {tag, st};
    endtask

    // Issues one command and waits (bounded) for sharers_v_o; lat counts cycles after accept.
    task automatic run_cmd(input logic [5:0] wg, input logic [TW-1:0] tag, input logic [1:0] req,
                           input logic [2:0] lru, input logic clr, output int lat,
                           output logic sv_first);
        @(negedge clk);
        bus.rd_v_i    = 1'b1;
        bus.clear_i   = clr;
        bus.wg_i      = wg;
        bus.tag_i     = tag;
        bus.req_lce_i = req;
        bus.lru_way_i = lru;
        @(posedge clk);
        #1;
        bus.rd_v_i  = 1'b0;
        bus.clear_i = 1'b0;
        addr_q.delete();
        lat = 0;
        sv_first = 1'bx;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) sv_first = bus.sharers_v_o;
            if (bus.ram_v_o) addr_q.push_back(bus.ram_addr_o);
        end while (!bus.sharers_v_o && lat < 40);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
        n_cmp++; if (bus.sharers_v_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_sharers_v got=%b exp=0", bus.sharers_v_o); end
        n_cmp++; if (bus.ram_v_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_ram_v got=%b exp=0", bus.ram_v_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        n_cmp++; if ({bus.sharers_hits_o, bus.sharers_ways_o, bus.sharers_coh_states_o,
                      bus.lru_tag_o, bus.lru_coh_state_o} !== '0) begin n_fail++;
            $display("FAIL reset_vectors got nonzero hits=%h tag=%h", bus.sharers_hits_o,
                     bus.lru_tag_o); end
    endtask

    task automatic test_single_hit();
        int   lat;
        logic sv1;
        clear_rows();
        set_entry(2, 3, 28'h123, COH_S);
        run_cmd(6'd5, 28'h123, 2'd0, 3'd0, 1'b0, lat, sv1);
        n_cmp++; if (lat !== 6) begin n_fail++;
            $display("FAIL hit_latency got=%0d exp=6", lat); end
        n_cmp++; if (addr_q.size() !== 4) begin n_fail++;
            $display("FAIL hit_read_count got=%0d exp=4", addr_q.size()); end
        for (int i = 0; i < addr_q.size() && i < 4; i++) begin
            n_cmp++; if (addr_q[i] !== 8'(5*4 + i)) begin n_fail++;
                $display("FAIL hit_addr[%0d] got=%h exp=%h", i, addr_q[i], 8'(5*4 + i)); end
        end
        n_cmp++; if (bus.sharers_hits_o !== 4'b0100) begin n_fail++;
            $display("FAIL hit_hits got=%b exp=0100", bus.sharers_hits_o); end
        n_cmp++; if (bus.sharers_ways_o !== 12'h0C0) begin n_fail++;
            $display("FAIL hit_ways got=%h exp=0c0", bus.sharers_ways_o); end
        n_cmp++; if (bus.sharers_coh_states_o !== 12'h040) begin n_fail++;
            $display("FAIL hit_states got=%h exp=040", bus.sharers_coh_states_o); end
        n_cmp++; if ({bus.ready_o, bus.busy_o} !== 2'b10) begin n_fail++;
            $display("FAIL hit_done_ready_busy got=%b exp=10", {bus.ready_o, bus.busy_o}); end
        @(negedge clk);
        n_cmp++; if (bus.sharers_hits_o !== 4'b0100 || bus.sharers_v_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_hold got hits=%b v=%b exp=0100/1", bus.sharers_hits_o,
                     bus.sharers_v_o); end
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        n_cmp++; if ({bus.sharers_v_o, bus.ready_o, bus.busy_o} !== 3'b010) begin n_fail++;
            $display("FAIL clear_idle got v/rdy/busy=%b exp=010",
                     {bus.sharers_v_o, bus.ready_o, bus.busy_o}); end
    endtask

    task automatic test_invalid_match();
        int   lat;
        logic sv1;
        clear_rows();
        set_entry(1, 0, 28'h55, COH_I);
        set_entry(0, 4, 28'h66, COH_M);
        run_cmd(6'd7, 28'h55, 2'd2, 3'd1, 1'b0, lat, sv1);
        n_cmp++; if ({bus.sharers_hits_o, bus.sharers_ways_o, bus.sharers_coh_states_o}
                     !== '0) begin n_fail++;
            $display("FAIL inval_vectors got hits=%b ways=%h states=%h exp=0",
                     bus.sharers_hits_o, bus.sharers_ways_o, bus.sharers_coh_states_o); end
    endtask

    task automatic test_lru();
        int   lat;
        logic sv1;
        clear_rows();
        set_entry(1, 6, 28'h7, COH_M);
        set_entry(3, 1, 28'h9, COH_O);
        set_entry(3, 7, 28'h9, COH_E);
        run_cmd(6'd12, 28'h9, 2'd1, 3'd6, 1'b0, lat, sv1);
        n_cmp++; if (bus.lru_tag_o !== 28'h7) begin n_fail++;
            $display("FAIL lru_tag got=%h exp=7", bus.lru_tag_o); end
        n_cmp++; if (bus.lru_coh_state_o !== COH_M) begin n_fail++;
            $display("FAIL lru_state got=%b exp=110", bus.lru_coh_state_o); end
        n_cmp++; if ({bus.lru_cached_excl_flag_o, bus.lru_dirty_flag_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL lru_flags got=%b exp=11",
                     {bus.lru_cached_excl_flag_o, bus.lru_dirty_flag_o}); end
        n_cmp++; if (bus.sharers_hits_o !== 4'b1000) begin n_fail++;
            $display("FAIL lru_hits got=%b exp=1000", bus.sharers_hits_o); end
        n_cmp++; if (bus.sharers_ways_o !== 12'h200 || bus.sharers_coh_states_o !== 12'hE00)
        begin n_fail++;
            $display("FAIL multihit_lowest got ways=%h states=%h exp=200/e00",
                     bus.sharers_ways_o, bus.sharers_coh_states_o); end
    endtask

    // Starts in DONE from the previous test; new command arrives together with clear.
    task automatic test_back_to_back();
        int   lat;
        logic sv1;
        clear_rows();
        set_entry(0, 0, 28'hAB, COH_E);
        n_cmp++; if (bus.sharers_v_o !== 1'b1) begin n_fail++;
            $display("FAIL b2b_start_done got=%b exp=1", bus.sharers_v_o); end
        run_cmd(6'd9, 28'hAB, 2'd0, 3'd0, 1'b1, lat, sv1);
        n_cmp++; if (sv1 !== 1'b0) begin n_fail++;
            $display("FAIL b2b_v_drop got=%b exp=0", sv1); end
        n_cmp++; if (lat !== 6) begin n_fail++;
            $display("FAIL b2b_latency got=%0d exp=6", lat); end
        n_cmp++; if (addr_q.size() < 1 || addr_q[0] !== 8'(9*4)) begin n_fail++;
            $display("FAIL b2b_first_addr got_n=%0d exp=%h", addr_q.size(), 8'(9*4)); end
        n_cmp++; if (bus.sharers_hits_o !== 4'b0001 || bus.sharers_ways_o !== 12'h000
                     || bus.sharers_coh_states_o !== 12'h002) begin n_fail++;
            $display("FAIL b2b_vectors got hits=%b ways=%h states=%h exp=0001/000/002",
                     bus.sharers_hits_o, bus.sharers_ways_o, bus.sharers_coh_states_o); end
        n_cmp++; if (bus.lru_tag_o !== 28'hAB
                     || {bus.lru_cached_excl_flag_o, bus.lru_dirty_flag_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_lru got tag=%h flags=%b exp=ab/10", bus.lru_tag_o,
                     {bus.lru_cached_excl_flag_o, bus.lru_dirty_flag_o}); end
    endtask

    task automatic test_reset_mid_read();
        logic saw_v;
        clear_rows();
        for (int i = 0; i < NL; i++) set_entry(i, 0, 28'h42, COH_M);
        @(negedge clk);
        bus.rd_v_i    = 1'b1;
        bus.wg_i      = 6'd3;
        bus.tag_i     = 28'h42;
        bus.req_lce_i = 2'd1;
        bus.lru_way_i = 3'd0;
        @(posedge clk);
        #1 bus.rd_v_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if ({bus.ready_o, bus.busy_o, bus.ram_v_o, bus.sharers_v_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_mid_state got rdy/busy/ramv/v=%b exp=1000",
                     {bus.ready_o, bus.busy_o, bus.ram_v_o, bus.sharers_v_o}); end
        saw_v = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.sharers_v_o !== 1'b0) saw_v = 1'b1;
        end
        n_cmp++; if (saw_v !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_no_pulse got=%b exp=0", saw_v); end
        n_cmp++; if (bus.sharers_hits_o !== 4'b0000 || bus.lru_tag_o !== 28'h0
                     || bus.sharers_coh_states_o !== 12'h000) begin n_fail++;
            $display("FAIL rst_mid_late_data got hits=%b lru_tag=%h exp=0/0",
                     bus.sharers_hits_o, bus.lru_tag_o); end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.rd_v_i    = 1'b0;
        bus.clear_i   = 1'b0;
        bus.wg_i      = '0;
        bus.tag_i     = '0;
        bus.req_lce_i = '0;
        bus.lru_way_i = '0;
        clear_rows();
        test_reset();
        test_single_hit();
        test_invalid_match();
        test_lru();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
